// File: rtl/game_pkg.sv
// Shared game geometry defaults, counter sizing and the cheese FSM state type.
package game_pkg;

  localparam int POS_W        = 11;
  localparam int OBJ_W_DEF    = 20;
  localparam int OBJ_H_DEF    = 20;
  localparam int PLAYER_W_DEF = 32;
  localparam int PLAYER_H_DEF = 32;
  localparam int FRAME_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_LATCH  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HIDDEN = 2'd3
  } cheese_state_e;

  // Position plus size, one bit wider so the far edge never wraps.
  function automatic logic [POS_W:0] far_edge(input logic [POS_W-1:0] pos,
                                              input logic [POS_W-1:0] size);
    return {1'b0, pos} + {1'b0, size};
  endfunction

endpackage

// File: rtl/pos_if.sv
// Screen position bundle (x, y) passed between the spawn generator and object logic.
interface pos_if;
  import game_pkg::*;

  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;

  modport in  (input  x, input  y);
  modport out (output x, output y);

endinterface

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle intersection; edges that only touch do not overlap.
module rect_overlap
  import game_pkg::*;
(
  input  logic [POS_W-1:0] a_x_i,
  input  logic [POS_W-1:0] a_y_i,
  input  logic [POS_W-1:0] a_w_i,
  input  logic [POS_W-1:0] a_h_i,
  input  logic [POS_W-1:0] b_x_i,
  input  logic [POS_W-1:0] b_y_i,
  input  logic [POS_W-1:0] b_w_i,
  input  logic [POS_W-1:0] b_h_i,
  output logic             overlap_o
);

  logic x_hit;
  logic y_hit;

  assign x_hit = ({1'b0, a_x_i} < far_edge(b_x_i, b_w_i)) &&
                 ({1'b0, b_x_i} < far_edge(a_x_i, a_w_i));
  assign y_hit = ({1'b0, a_y_i} < far_edge(b_y_i, b_h_i)) &&
                 ({1'b0, b_y_i} < far_edge(a_y_i, a_h_i));

  assign overlap_o = x_hit && y_hit;

endmodule

// File: rtl/cheese_collect.sv
// Cheese pickup controller: request a spawn position, show the cheese until the player
// touches it, then hide it for RESPAWN_FRAMES frames. Macro CHEESE_TIMEOUT_EN adds a
// respawn of an uncollected cheese after TIMEOUT_FRAMES frames.
module cheese_collect
  import game_pkg::*;
#(
  parameter int OBJ_W          = OBJ_W_DEF,
  parameter int OBJ_H          = OBJ_H_DEF,
  parameter int PLAYER_W       = PLAYER_W_DEF,
  parameter int PLAYER_H       = PLAYER_H_DEF,
  parameter int RESPAWN_FRAMES = 60,
  parameter int SCORE_W        = 8
`ifdef CHEESE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_FRAMES = 600
`endif
) (
  input  logic               clk,
  input  logic               rst,
  pos_if.in                  pin,
  input  logic [POS_W-1:0]   player_x,
  input  logic [POS_W-1:0]   player_y,
  input  logic               frame_tick,
  output logic               rnd_generate,
  pos_if.out                 cheese,
  output logic               cheese_visible,
  output logic [SCORE_W-1:0] score,
  output logic               collected
);

  localparam logic [POS_W-1:0]       OBJ_W_V    = POS_W'(OBJ_W);
  localparam logic [POS_W-1:0]       OBJ_H_V    = POS_W'(OBJ_H);
  localparam logic [POS_W-1:0]       PLAYER_W_V = POS_W'(PLAYER_W);
  localparam logic [POS_W-1:0]       PLAYER_H_V = POS_W'(PLAYER_H);
  localparam logic [FRAME_CNT_W-1:0] RESPAWN_V  = FRAME_CNT_W'(RESPAWN_FRAMES);
  localparam logic [SCORE_W-1:0]     SCORE_MAX  = '1;
`ifdef CHEESE_TIMEOUT_EN
  localparam logic [FRAME_CNT_W-1:0] TIMEOUT_V  = FRAME_CNT_W'(TIMEOUT_FRAMES);
`endif

  cheese_state_e          state_q;
  logic [POS_W-1:0]       cheese_x_q;
  logic [POS_W-1:0]       cheese_y_q;
  logic                   rnd_q;
  logic                   visible_q;
  logic                   collected_q;
  logic [SCORE_W-1:0]     score_q;
  logic [SCORE_W-1:0]     score_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
  logic                   overlap;
  logic                   respawn_due;

  rect_overlap u_overlap (
    .a_x_i     (player_x),
    .a_y_i     (player_y),
    .a_w_i     (PLAYER_W_V),
    .a_h_i     (PLAYER_H_V),
    .b_x_i     (cheese_x_q),
    .b_y_i     (cheese_y_q),
    .b_w_i     (OBJ_W_V),
    .b_h_i     (OBJ_H_V),
    .overlap_o (overlap)
  );

  assign score_d     = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
  assign frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
  // A zero respawn delay leaves HIDDEN on the very next cycle, tick or not.
  assign respawn_due = (RESPAWN_V == '0) || (frame_tick && (frame_cnt_d == RESPAWN_V));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_REQ;
      cheese_x_q  <= '0;
      cheese_y_q  <= '0;
      rnd_q       <= 1'b0;
      visible_q   <= 1'b0;
      collected_q <= 1'b0;
      score_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      collected_q <= 1'b0;
      unique case (state_q)
        ST_REQ: begin
          // Entry from HIDDEN raises the request on the way in; out of reset it is raised here.
          if (rnd_q) begin
            rnd_q   <= 1'b0;
            state_q <= ST_LATCH;
          end else begin
            rnd_q <= 1'b1;
          end
        end
        ST_LATCH: begin
          cheese_x_q  <= pin.x;
          cheese_y_q  <= pin.y;
          visible_q   <= 1'b1;
          frame_cnt_q <= '0;
          state_q     <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (overlap) begin
            collected_q <= 1'b1;
            score_q     <= score_d;
            frame_cnt_q <= '0;
            visible_q   <= 1'b0;
            state_q     <= ST_HIDDEN;
          end
`ifdef CHEESE_TIMEOUT_EN
          else if (frame_tick) begin
            if (frame_cnt_d >= TIMEOUT_V) begin
              frame_cnt_q <= '0;
              visible_q   <= 1'b0;
              rnd_q       <= 1'b1;
              state_q     <= ST_REQ;
            end else begin
              frame_cnt_q <= frame_cnt_d;
            end
          end
`endif
        end
        ST_HIDDEN: begin
          if (respawn_due) begin
            frame_cnt_q <= '0;
            rnd_q       <= 1'b1;
            state_q     <= ST_REQ;
          end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_d;
          end
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

  assign rnd_generate   = rnd_q;
  assign cheese.x       = cheese_x_q;
  assign cheese.y       = cheese_y_q;
  assign cheese_visible = visible_q;
  assign score          = score_q;
  assign collected      = collected_q;

endmodule

// File: tb/tb_cheese_collect.sv
// Directed bench for cheese_collect with a per-cycle behavioural model of the pickup game.
`timescale 1ns/1ps
module tb_cheese_collect;
  import game_pkg::*;

  localparam int RESPAWN = 3;
  localparam int SW      = 2;
  localparam int TMO     = 5;
  localparam int SMAX    = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [10:0]   player_x;
  logic [10:0]   player_y;
  logic          frame_tick;
  logic          rnd_generate;
  logic          cheese_visible;
  logic          collected;
  logic [SW-1:0] score;

  pos_if pin_if ();
  pos_if cheese_if ();

  int vectors     = 0;
  int miscompares = 0;

  cheese_collect #(
    .RESPAWN_FRAMES (RESPAWN),
    .SCORE_W        (SW)
`ifdef CHEESE_TIMEOUT_EN
    , .TIMEOUT_FRAMES (TMO)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pin            (pin_if),
    .player_x       (player_x),
    .player_y       (player_y),
    .frame_tick     (frame_tick),
    .rnd_generate   (rnd_generate),
    .cheese         (cheese_if),
    .cheese_visible (cheese_visible),
    .score          (score),
    .collected      (collected)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a spawn takes three edges (request, generator latency, capture), the cheese is
  // then live until touched, and the hidden phase ends once RESPAWN frame ticks are seen.
  int m_age   = 0;
  bit m_rnd   = 0;
  bit m_vis   = 0;
  bit m_coll  = 0;
  int m_cx    = 0;
  int m_cy    = 0;
  int m_score = 0;
  int m_ticks = 0;

  function automatic bit touches(input int px, input int py, input int cx, input int cy);
    return (px < cx + 20) && (cx < px + 32) && (py < cy + 20) && (cy < py + 32);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age = 0; m_rnd = 0; m_vis = 0; m_coll = 0;
      m_cx = 0; m_cy = 0; m_score = 0; m_ticks = 0;
    end else begin
      m_rnd  = 0;
      m_coll = 0;
      if (m_age >= 0) begin
        m_age++;
        if (m_age == 1) m_rnd = 1;
        if (m_age == 3) begin
          m_cx = int'(pin_if.x); m_cy = int'(pin_if.y);
          m_vis = 1; m_age = -1; m_ticks = 0;
        end
      end else if (m_vis) begin
        if (touches(int'(player_x), int'(player_y), m_cx, m_cy)) begin
          m_coll = 1;
          if (m_score < SMAX) m_score++;
          m_vis = 0; m_ticks = 0;
        end
`ifdef CHEESE_TIMEOUT_EN
        else if (frame_tick) begin
          m_ticks++;
          if (m_ticks == TMO) begin
            m_vis = 0; m_age = 1; m_rnd = 1;
          end
        end
`endif
      end else begin
        if (frame_tick) m_ticks++;
        if (m_ticks >= RESPAWN) begin
          m_age = 1; m_rnd = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    cmp("rnd_generate", int'(rnd_generate), int'(m_rnd));
    cmp("collected", int'(collected), int'(m_coll));
    cmp("cheese_visible", int'(cheese_visible), int'(m_vis));
    cmp("cheese_x", int'(cheese_if.x), m_cx);
    cmp("cheese_y", int'(cheese_if.y), m_cy);
    cmp("score", int'(score), m_score);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
  endtask

  initial begin
    player_x = 11'd1000; player_y = 11'd1000; frame_tick = 1'b0;
    pin_if.x = 11'd300;  pin_if.y = 11'd200;
    step(2);
    cmp("reset_score", int'(score), 0);
    cmp("reset_rnd", int'(rnd_generate), 0);
    cmp("reset_visible", int'(cheese_visible), 0);
    cmp("reset_cheese_x", int'(cheese_if.x), 0);
    rst = 1'b0;

    step(1);
    cmp("spawn_rnd_cycle1", int'(rnd_generate), 1);
    step(1);
    cmp("spawn_rnd_cycle2", int'(rnd_generate), 0);
    cmp("spawn_not_yet_visible", int'(cheese_visible), 0);
    step(1);
    cmp("spawn_x", int'(cheese_if.x), 300);
    cmp("spawn_y", int'(cheese_if.y), 200);
    cmp("spawn_visible", int'(cheese_visible), 1);

    player_x = 11'd290; player_y = 11'd190;
    step(1);
    cmp("pickup1_collected", int'(collected), 1);
    cmp("pickup1_score", int'(score), 1);
    cmp("pickup1_hidden", int'(cheese_visible), 0);
    cmp("model_score_after_pickup1", m_score, 1);
    step(2);
    cmp("hidden_overlap_ignored", int'(score), 1);

    player_x = 11'd1000; player_y = 11'd1000;
    pin_if.x = 11'd500;  pin_if.y = 11'd400;
    tick_pulse();
    tick_pulse();
    cmp("no_respawn_after_2_ticks", int'(cheese_visible), 0);
    frame_tick = 1'b1;
    step(1);
    cmp("respawn_rnd_after_tick3", int'(rnd_generate), 1);
    frame_tick = 1'b0;
    step(2);
    cmp("respawn_x", int'(cheese_if.x), 500);
    cmp("respawn_y", int'(cheese_if.y), 400);
    cmp("model_respawn_x", m_cx, 500);

    player_x = 11'd468; player_y = 11'd390;
    step(3);
    cmp("edge_touch_no_pickup", int'(score), 1);
    cmp("edge_touch_still_visible", int'(cheese_visible), 1);
    player_x = 11'd469;
    step(1);
    cmp("edge_plus1_pickup", int'(collected), 1);
    cmp("pickup2_score", int'(score), 2);

    player_x = 11'd1000; player_y = 11'd1000;
    pin_if.x = 11'd100;  pin_if.y = 11'd50;
    tick_pulse(); tick_pulse(); tick_pulse();
    step(2);
    cmp("spawn3_visible", int'(cheese_visible), 1);
    player_x = 11'd100; player_y = 11'd50; frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    cmp("pickup3_with_tick", int'(collected), 1);
    cmp("pickup3_score", int'(score), 3);
    pin_if.x = 11'd700; pin_if.y = 11'd600;
    tick_pulse(); tick_pulse();
    cmp("same_cycle_tick_not_counted", int'(cheese_visible), 0);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    cmp("respawn4_rnd", int'(rnd_generate), 1);
    step(2);
    cmp("spawn4_x", int'(cheese_if.x), 700);

`ifndef CHEESE_TIMEOUT_EN
    player_x = 11'd1000; player_y = 11'd1000;
    repeat (7) tick_pulse();
    cmp("no_timeout_still_visible", int'(cheese_visible), 1);
`endif
    player_x = 11'd700; player_y = 11'd600;
    step(1);
    cmp("pickup4_saturated_pulse", int'(collected), 1);
    cmp("pickup4_score_saturated", int'(score), 3);
    cmp("model_score_saturated", m_score, 3);

    step(2);
    rst = 1'b1;
    #1;
    cmp("midrst_score", int'(score), 0);
    cmp("midrst_cheese_x", int'(cheese_if.x), 0);
    cmp("midrst_rnd", int'(rnd_generate), 0);
    step(1);
    rst = 1'b0;
    player_x = 11'd1000; player_y = 11'd1000;
    step(1);
    cmp("post_rst_rnd", int'(rnd_generate), 1);
    step(2);
    cmp("post_rst_visible", int'(cheese_visible), 1);

`ifdef CHEESE_TIMEOUT_EN
    repeat (4) tick_pulse();
    cmp("timeout_not_yet", int'(cheese_visible), 1);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    cmp("timeout_rnd", int'(rnd_generate), 1);
    cmp("timeout_no_collect", int'(collected), 0);
    cmp("timeout_score_unchanged", int'(score), 0);
    step(4);
    cmp("timeout_respawn_visible", int'(cheese_visible), 1);
`endif

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
